// File: rtl/div_clock_monitor.sv
// Purpose : receive-side monitor for a ripple-divided clock; synchronizes it into 'clock',
//           emits rise/fall pulses, measures rise-to-rise period, flags loss of the clock.
// Latency : pulses and measurement updates appear SYNC_STAGES+1 clock edges after the input
//           transition is first sampled.
// Backpressure: none; a free-running observer that never stalls its source.
//
// Optional build macro: DIV_MON_TOL_CHECK_EN
//   defined     -> period_err compares each loaded period against EXPECTED_PERIOD +/- TOLERANCE
//   not defined -> period_err is tied low and no comparator is built
//
// Ports
//   clock         in   1          system clock, all logic on its rising edge
//   reset         in   1          asynchronous, active-low reset
//   div_clock_in  in   1          divided clock to monitor, asynchronous to clock
//   clear         in   1          synchronous clear of the measurement state
//   rise_pulse    out  1          one-cycle pulse per synchronized rising edge
//   fall_pulse    out  1          one-cycle pulse per synchronized falling edge
//   period        out  CNT_WIDTH  last measured rise-to-rise period in clocks
//   period_valid  out  1          period holds a measurement from two consecutive rises
//   timeout       out  1          TIMEOUT clocks elapsed with no detected edge
//   edge_count    out  16         counted rising edges, wraps 0xFFFF -> 0
//   period_err    out  1          loaded period outside tolerance (tolerance build only)

module div_clock_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 20,
    parameter int TIMEOUT         = 131072,
    parameter int EXPECTED_PERIOD = 131072,
    parameter int TOLERANCE       = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 div_clock_in,
    input  logic                 clear,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 timeout,
    output logic [15:0]          edge_count,
    output logic                 period_err
);

    // Idle counter must be able to hold the value TIMEOUT itself.
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("div_clock_monitor: SYNC_STAGES must be at least 2");
        end
        if (CNT_WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cnt
            $error("div_clock_monitor: CNT_WIDTH and TIMEOUT must be positive");
        end
        if (EXPECTED_PERIOD < 1 || TOLERANCE < 0) begin : g_bad_tol
            $error("div_clock_monitor: EXPECTED_PERIOD must be positive, TOLERANCE non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2,
        S_LOST   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise_pulse;
    logic                   r_fall_pulse;
    logic                   w_sync_out;
    logic                   w_rise;
    logic                   w_fall;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     =  w_sync_out & ~r_prev;
    assign w_fall     = ~w_sync_out &  r_prev;

    // The synchronizer and pulse registers ignore 'clear': edges keep being
    // reported even while the measurement state is held cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync       <= '0;
            r_prev       <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], div_clock_in};
            r_prev       <= w_sync_out;
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
        end
    end

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [IDLE_W-1:0]     r_idle;
    logic [CNT_WIDTH-1:0]  r_period;
    logic                  r_period_valid;
    logic                  r_timeout;
    logic [15:0]           r_edge_count;
    logic                  w_load;
    logic                  w_idle_hit;

    // A rise only produces a period once a previous rise has started the count.
    assign w_load = w_rise && (r_state == S_ARMED || r_state == S_LOCKED);

    // The idle counter reaches TIMEOUT on this edge; any edge restarts it instead.
    assign w_idle_hit = !w_rise && !w_fall && (r_idle == IDLE_W'(TIMEOUT - 1));

`ifdef DIV_MON_TOL_CHECK_EN
    // Compare in a width that holds both the counter and EXPECTED_PERIOD,
    // so narrow counters against large nominal periods still compare correctly.
    localparam int CMP_W = ((CNT_WIDTH > 31) ? CNT_WIDTH : 31) + 1;

    logic [CMP_W-1:0] w_cnt_ext;
    logic [CMP_W-1:0] w_exp;
    logic [CMP_W-1:0] w_diff;
    logic             w_out_of_tol;
    logic             r_period_err;

    assign w_cnt_ext    = CMP_W'(r_cnt);
    assign w_exp        = CMP_W'(EXPECTED_PERIOD);
    assign w_diff       = (w_cnt_ext >= w_exp) ? (w_cnt_ext - w_exp) : (w_exp - w_cnt_ext);
    assign w_out_of_tol = (w_diff > CMP_W'(TOLERANCE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period_err <= 1'b0;
        end else if (clear) begin
            r_period_err <= 1'b0;
        end else if (w_load) begin
            r_period_err <= w_out_of_tol;
        end
    end

    assign period_err = r_period_err;
`else
    assign period_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_idle         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_edge_count   <= '0;
        end else if (clear) begin
            // Clear takes priority over a rise detected in the same cycle:
            // that rise is neither counted nor allowed to arm the FSM.
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_idle         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_edge_count   <= '0;
        end else begin
            // Period counter: restarts at 1 on a rise so that the value held
            // just before the next rise equals the rise-to-rise distance.
            if (w_rise) begin
                r_cnt <= CNT_WIDTH'(1);
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end

            // Idle counter saturates at TIMEOUT so the loss indication is sticky.
            if (w_rise || w_fall) begin
                r_idle <= '0;
            end else if (r_idle != IDLE_W'(TIMEOUT)) begin
                r_idle <= r_idle + IDLE_W'(1);
            end

            if (w_rise) begin
                r_edge_count <= r_edge_count + 16'd1;
                r_timeout    <= 1'b0;
            end

            if (w_load) begin
                r_period       <= r_cnt;
                r_period_valid <= 1'b1;
            end

            case (r_state)
                S_IDLE:   if (w_rise) r_state <= S_ARMED;
                S_ARMED:  if (w_rise) r_state <= S_LOCKED;
                S_LOCKED: r_state <= S_LOCKED;
                S_LOST:   if (w_rise) r_state <= S_ARMED;
                default:  r_state <= S_IDLE;
            endcase

            // Loss of clock overrides the state decode; it cannot coincide
            // with a rise because w_idle_hit excludes edges.
            if (w_idle_hit) begin
                r_state        <= S_LOST;
                r_timeout      <= 1'b1;
                r_period_valid <= 1'b0;
            end
        end
    end

    assign rise_pulse   = r_rise_pulse;
    assign fall_pulse   = r_fall_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign edge_count   = r_edge_count;

endmodule
